// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, the PC stage, instruction memory and the decode consumer.
// The master modport is the fetch unit's view; slave is the surrounding environment.
interface fetch_unit_if;
    logic [15:0] pc;
    logic        inc;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (
        input  pc, flush, mem_ack, mem_rdata, instr_ready,
        output inc, mem_req, mem_addr, instr_valid, instr
    );

    modport slave (
        output pc, flush, mem_ack, mem_rdata, instr_ready,
        input  inc, mem_req, mem_addr, instr_valid, instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a small circular
// instruction buffer, with branch flush and drop of a read that was in flight at the flush.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_UPD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          drop_q, drop_d;
    logic          mem_req_q, mem_req_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          inc_q, inc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   buf_q [DEPTH];
    logic [15:0]   buf_d [DEPTH];
    logic          push_s;
    logic          pop_s;
    logic          valid_s;

    // Fetch sequencing: issue, wait for ack, then give the PC stage one cycle to increment
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inc_d      = 1'b0;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.flush && (count_q < CW'(DEPTH))) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.pc;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A flush seen at any point of this read makes the word stale
                    if (drop_q || bus.flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        push_s  = 1'b1;
                        inc_d   = 1'b1;
                        state_d = ST_UPD;
                    end
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_UPD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // Circular buffer bookkeeping; flush wins over a coincident push or pop
    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = (count_q != CW'(0)) && bus.instr_ready;
        if (bus.flush) begin
            head_d  = PW'(0);
            tail_d  = PW'(0);
            count_d = CW'(0);
        end else begin
            if (push_s) begin
                buf_d[tail_q] = bus.mem_rdata;
                tail_d        = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers; reset also drops an in-flight request without waiting for clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
            inc_q      <= 1'b0;
            head_q     <= PW'(0);
            tail_q     <= PW'(0);
            count_q    <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inc_q      <= inc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
        end
    end

    assign valid_s         = (count_q != CW'(0));
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    // A branch in the increment cycle must not also bump the redirected PC
    assign bus.inc         = inc_q & ~bus.flush;
    assign bus.instr_valid = valid_s;
    assign bus.instr       = valid_s ? buf_q[head_q] : 16'h0000;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction buffer entries; legal values are 2 or 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset; SHALL be asynchronous and active-low (reset=0 resets the block).
REQ-004 pc  input  16  current value from the program-counter stage.
REQ-005 inc  output  1  one-cycle pulse to the program-counter stage's inc input, requesting pc+1.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  16  read address; SHALL be stable while mem_req=1.
REQ-008 mem_ack  input  1  memory response strobe; mem_rdata is valid in the same cycle.
REQ-009 mem_rdata  input  16  instruction word returned by memory.
REQ-010 flush  input  1  branch-taken pulse, coincident with add/sub driven to the program-counter stage.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr  output  16  buffer head word; SHALL be 16'h0000 when instr_valid=0.
REQ-013 instr_ready  input  1  consumer accepts the head when instr_valid=1 and instr_ready=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ, UPD.
REQ-015 IDLE -> REQ SHALL occur when count<DEPTH and flush=0. On that edge, mem_addr SHALL load pc and mem_req SHALL rise.
REQ-016 In REQ, mem_req SHALL stay 1 and mem_addr SHALL stay constant until an edge where mem_ack=1.
REQ-017 On an REQ edge with mem_ack=1 and the drop flag clear, the block SHALL:
  - push mem_rdata into the buffer tail;
  - assert inc for exactly the next cycle;
  - deassert mem_req;
  - go to UPD.
REQ-018 UPD SHALL last one cycle, so pc reflects the increment, then go to IDLE.
REQ-019 A request SHALL NOT be issued in UPD. Each fetched word therefore takes at least 3 cycles: REQ with same-cycle ack, then UPD, then IDLE.
REQ-020 The buffer SHALL be a circular FIFO:
  - head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0;
  - count of log2(DEPTH)+1 bits ranging 0..DEPTH.
REQ-021 A pop SHALL occur when instr_valid=1 and instr_ready=1. A simultaneous push and pop SHALL leave count unchanged.
REQ-022 A push SHALL never find the buffer full, because REQ-015 checks count before issuing.
REQ-023 flush=1 SHALL clear count, head and tail on that edge. instr_valid SHALL be 0 in the following cycle.
REQ-024 flush during REQ SHALL set a drop flag. The pending ack SHALL then be consumed with no push and no inc, and the FSM SHALL go to IDLE.
REQ-025 flush during UPD SHALL suppress the scheduled inc pulse.
REQ-026 inc SHALL never be 1 in a cycle where flush=1.
REQ-027 flush in IDLE SHALL block issue for that cycle. The next request SHALL use the redirected pc one cycle later.
REQ-028 mem_ack outside REQ SHALL be ignored.
REQ-029 A pop and a flush on the same edge SHALL resolve to the flush result (empty).

Reset
REQ-030 While reset=0, the block SHALL hold:
  - state IDLE, drop flag 0;
  - mem_req=0, mem_addr=16'h0000, inc=0;
  - count=0, pointers=0;
  - instr_valid=0, instr=16'h0000.
REQ-031 Reset asserted mid-transaction SHALL drop mem_req immediately, without waiting for clk, and abandon the fetch. A later mem_ack SHALL be ignored.
REQ-032 After reset deasserts, the first request SHALL issue on the first clk edge with count=0 and flush=0.

Verification
REQ-033 Fetch: pc=16'h0010, reset release, mem_ack in the first REQ cycle with rdata=16'hA5A5 -> mem_addr=16'h0010, inc pulses once, instr_valid=1 with instr=16'hA5A5.
REQ-034 Fill: instr_ready=0, DEPTH=2, memory always acks -> exactly 2 requests and 2 inc pulses, then mem_req stays 0. Raising instr_ready yields both words in order, and fetching resumes.
REQ-035 Wrap: instr_ready=1 for 10 fetches of 16'h0001..16'h000A -> all 10 delivered in order with no loss; pointers wrap at least 4 times.
REQ-036 Flush in REQ: flush pulse while ack is delayed 3 cycles -> returned word not pushed, no inc, buffer empty, next mem_addr equals the redirected pc.
REQ-037 Async reset: reset=0 mid-REQ between clk edges -> mem_req=0 and instr_valid=0 before the next edge; state resumes as in REQ-032.
REQ-038 Concurrent pop/push: count=1 with pop and ack on the same edge -> count stays 1, and order is preserved.
